// File: rtl/generic_beat_packer.sv
// Packs BEAT_WIDTH-bit input beats into one DATA_WIDTH-bit word with valid/ready on both sides.
// Optional build macro GENERIC_BEAT_PACKER_MSB_FIRST_EN places beat 0 in the top slot instead of the bottom slot.
module generic_beat_packer #(
    parameter int DATA_WIDTH = 2,
    parameter int BEAT_WIDTH = 1,
    localparam int N  = DATA_WIDTH / BEAT_WIDTH,
    localparam int CW = $clog2(N + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [BEAT_WIDTH-1:0] i_beat,
    input  logic                  i_last,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [CW-1:0]         o_count,
    output logic                  o_last
);

    if (DATA_WIDTH < 1 || BEAT_WIDTH < 1 || (DATA_WIDTH % BEAT_WIDTH) != 0) begin : g_badParams
        $error("generic_beat_packer: DATA_WIDTH must be a positive integer multiple of BEAT_WIDTH");
    end

    logic [DATA_WIDTH-1:0] r_acc;
    logic [CW-1:0]         r_cnt;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic [CW-1:0]         r_count;
    logic                  r_last;

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_complete;
    logic [CW-1:0]         w_slot;
    logic [DATA_WIDTH-1:0] w_word;

    // Ready depends only on the output register and downstream ready, never on i_valid/i_last.
    assign w_ready    = !r_valid || i_ready;
    assign w_accept   = i_valid && w_ready;
    assign w_complete = w_accept && ((r_cnt == CW'(N - 1)) || i_last);

`ifdef GENERIC_BEAT_PACKER_MSB_FIRST_EN
    assign w_slot = CW'(N - 1) - r_cnt;
`else
    assign w_slot = r_cnt;
`endif

    // Unfilled slots are already zero because the accumulator clears on every completed word.
    always_comb begin
        w_word = r_acc;
        for (int k = 0; k < N; k++) begin
            if (w_slot == CW'(k)) begin
                w_word[k*BEAT_WIDTH +: BEAT_WIDTH] = i_beat;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_complete) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_acc <= w_word;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A completing beat overwrites the output register even while the previous word drains.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_count <= '0;
            r_last  <= 1'b0;
        end else if (w_complete) begin
            r_valid <= 1'b1;
            r_data  <= w_word;
            r_count <= r_cnt + 1'b1;
            r_last  <= i_last;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_ready = w_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_count = r_count;
    assign o_last  = r_last;

endmodule

// File: tb/tb_generic_beat_packer.sv
// Scoreboard bench for generic_beat_packer: an 8/2 instance carries most tests, a 2/1 instance covers the minimal case.
module tb_generic_beat_packer;

    typedef struct {
        logic [7:0] data;
        logic [2:0] count;
        logic       last;
    } word_t;

    typedef struct {
        logic [1:0] data;
        logic [1:0] count;
        logic       last;
    } word2_t;

    logic       clk = 1'b0;
    logic       iRst;

    logic       iValid;
    logic       oReady;
    logic [1:0] iBeat;
    logic       iLast;
    logic       oValid;
    logic       iReady;
    logic [7:0] oData;
    logic [2:0] oCount;
    logic       oLast;

    logic       u2Valid;
    logic       u2OReady;
    logic       u2Beat;
    logic       u2Last;
    logic       u2OValid;
    logic       u2Ready;
    logic [1:0] u2Data;
    logic [1:0] u2Count;
    logic       u2OLast;

    int errors = 0;
    int checks = 0;

    word_t  sbQ[$];
    word2_t sbQ2[$];

    always #5 clk = ~clk;

    generic_beat_packer #(.DATA_WIDTH(8), .BEAT_WIDTH(2)) u8 (
        .i_clk(clk), .i_rst(iRst),
        .i_valid(iValid), .o_ready(oReady), .i_beat(iBeat), .i_last(iLast),
        .o_valid(oValid), .i_ready(iReady), .o_data(oData), .o_count(oCount), .o_last(oLast)
    );

    generic_beat_packer #(.DATA_WIDTH(2), .BEAT_WIDTH(1)) u2 (
        .i_clk(clk), .i_rst(iRst),
        .i_valid(u2Valid), .o_ready(u2OReady), .i_beat(u2Beat), .i_last(u2Last),
        .o_valid(u2OValid), .i_ready(u2Ready), .o_data(u2Data), .o_count(u2Count), .o_last(u2OLast)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic expectWord(input logic [7:0] data, input logic [2:0] count, input logic last);
        word_t w;
        w.data  = data;
        w.count = count;
        w.last  = last;
        sbQ.push_back(w);
    endtask

    // Holds one beat on the u8 inputs until it is accepted; returns the number of stalled cycles.
    task automatic applyStimulus(input logic [1:0] beat, input logic last, output int stalls);
        iValid = 1'b1;
        iBeat  = beat;
        iLast  = last;
        stalls = 0;
        forever begin
            @(negedge clk);
            if (oReady) break;
            stalls++;
            if (stalls > 50) begin
                checkOutput("acceptTimeout", 32'(stalls), 0);
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iValid = 1'b0;
        iLast  = 1'b0;
    endtask

    task automatic resetPulse(input string tag);
        #2;
        iRst = 1'b0;
        #1;
        checkOutput({tag, "ValidCleared"}, oValid, 0);
        checkOutput({tag, "CountCleared"}, oCount, 0);
        checkOutput({tag, "DataCleared"}, oData, 0);
        sbQ.delete();
        @(negedge clk);
        iRst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (iRst && oValid && iReady) begin
            checkOutput("u8WordExpected", (sbQ.size() != 0), 1);
            if (sbQ.size() != 0) begin
                word_t w;
                w = sbQ.pop_front();
                checkOutput("u8Data", oData, w.data);
                checkOutput("u8Count", oCount, w.count);
                checkOutput("u8Last", oLast, w.last);
            end
        end
    end

    always @(negedge clk) begin
        if (iRst && u2OValid && u2Ready) begin
            checkOutput("u2WordExpected", (sbQ2.size() != 0), 1);
            if (sbQ2.size() != 0) begin
                word2_t w;
                w = sbQ2.pop_front();
                checkOutput("u2Data", u2Data, w.data);
                checkOutput("u2Count", u2Count, w.count);
                checkOutput("u2Last", u2OLast, w.last);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int st;
        int totalStalls;
        word2_t w2;
        logic [7:0] expA, expB, expFlush2, expFlush1, expFlush3, expFresh;
        logic [1:0] exp2;

`ifdef GENERIC_BEAT_PACKER_MSB_FIRST_EN
        expA = 8'hE4; expB = 8'h1B; expFlush2 = 8'h90; expFlush1 = 8'h40;
        expFlush3 = 8'hFC; expFresh = 8'hB1; exp2 = 2'b10;
`else
        expA = 8'h1B; expB = 8'hE4; expFlush2 = 8'h06; expFlush1 = 8'h01;
        expFlush3 = 8'h3F; expFresh = 8'h4E; exp2 = 2'b01;
`endif

        iRst = 1'b0;
        iValid = 1'b0; iBeat = '0; iLast = 1'b0; iReady = 1'b1;
        u2Valid = 1'b0; u2Beat = 1'b0; u2Last = 1'b0; u2Ready = 1'b1;
        #1;
        checkOutput("rstValid", oValid, 0);
        checkOutput("rstData", oData, 0);
        checkOutput("rstCount", oCount, 0);
        checkOutput("rstLast", oLast, 0);
        checkOutput("rstReady", oReady, 1);
        checkOutput("rstU2Valid", u2OValid, 0);
        #12;
        iRst = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] minimal 2/1 packer: beats 1,0");
        w2.data = exp2; w2.count = 2'd2; w2.last = 1'b0;
        sbQ2.push_back(w2);
        u2Valid = 1'b1; u2Beat = 1'b1;
        @(negedge clk); checkOutput("u2Ready0", u2OReady, 1);
        @(posedge clk); #1;
        u2Beat = 1'b0;
        @(negedge clk); checkOutput("u2Ready1", u2OReady, 1);
        @(posedge clk); #1;
        u2Valid = 1'b0;
        @(negedge clk); checkOutput("u2ValidAfterLatency", u2OValid, 1);
        @(posedge clk); #1;
        @(negedge clk); checkOutput("u2ValidOneCycle", u2OValid, 0);
        @(posedge clk); #1;

        $display("[TB] continuous 8 beats, no bubbles");
        totalStalls = 0;
        applyStimulus(2'd3, 0, st); totalStalls += st;
        applyStimulus(2'd2, 0, st); totalStalls += st;
        applyStimulus(2'd1, 0, st); totalStalls += st;
        expectWord(expA, 3'd4, 1'b0);
        applyStimulus(2'd0, 0, st); totalStalls += st;
        applyStimulus(2'd0, 0, st); totalStalls += st;
        applyStimulus(2'd1, 0, st); totalStalls += st;
        applyStimulus(2'd2, 0, st); totalStalls += st;
        expectWord(expB, 3'd4, 1'b0);
        applyStimulus(2'd3, 0, st); totalStalls += st;
        idle();
        checkOutput("continuousStalls", 32'(totalStalls), 0);
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] flush words with i_last");
        applyStimulus(2'd2, 0, st);
        expectWord(expFlush2, 3'd2, 1'b1);
        applyStimulus(2'd1, 1, st);
        expectWord(expFlush1, 3'd1, 1'b1);
        applyStimulus(2'd1, 1, st);
        idle();
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] backpressure for 5 cycles");
        iReady = 1'b0;
        expectWord(8'h55, 3'd4, 1'b0);
        applyStimulus(2'd1, 0, st);
        applyStimulus(2'd1, 0, st);
        applyStimulus(2'd1, 0, st);
        applyStimulus(2'd1, 0, st);
        iValid = 1'b1; iBeat = 2'd3; iLast = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bpReadyLow", oReady, 0);
            checkOutput("bpValidHeld", oValid, 1);
            checkOutput("bpDataHeld", oData, 8'h55);
            checkOutput("bpCountHeld", oCount, 3'd4);
            @(posedge clk);
            #1;
        end
        iReady = 1'b1;
        @(negedge clk);
        checkOutput("bpReadyRelease", oReady, 1);
        @(posedge clk);
        #1;
        applyStimulus(2'd3, 0, st);
        checkOutput("bpSecondBeatStalls", 32'(st), 0);
        expectWord(expFlush3, 3'd3, 1'b1);
        applyStimulus(2'd3, 1, st);
        idle();
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] reset with a held word, then mid-word");
        iReady = 1'b0;
        applyStimulus(2'd1, 0, st);
        applyStimulus(2'd1, 0, st);
        applyStimulus(2'd1, 0, st);
        applyStimulus(2'd1, 0, st);
        idle();
        resetPulse("rstHeld");
        iReady = 1'b1;
        applyStimulus(2'd2, 0, st);
        idle();
        resetPulse("rstMid");
        applyStimulus(2'd2, 0, st);
        applyStimulus(2'd3, 0, st);
        applyStimulus(2'd0, 0, st);
        expectWord(expFresh, 3'd4, 1'b0);
        applyStimulus(2'd1, 0, st);
        idle();
        repeat (3) @(posedge clk);
        #1;

        checkOutput("u8ScoreboardDrained", 32'(sbQ.size()), 0);
        checkOutput("u2ScoreboardDrained", 32'(sbQ2.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
